// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// EX-stage forwarding selects and the strobe bundles used internally.
package pipe_ctrl_pkg;

   // Architectural register index width (32 GPRs, x0 hard-wired zero).
   localparam int REG_AW = 5;

   // Controller FSM.
   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   // EX operand source selects.
   localparam logic [1:0] FWD_RF  = 2'd0;  // register file read data
   localparam logic [1:0] FWD_MEM = 2'd1;  // EX/MEM ALU result
   localparam logic [1:0] FWD_WB  = 2'd2;  // WB write data

   // Hold strobes, one per sequenced register.
   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
   } stall_t;

   // Bubble strobes, one per pipeline register.
   typedef struct packed {
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } flush_t;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one EX source register.
// EX/MEM has priority over WB because it holds the younger result;
// x0 is never forwarded since its architectural value is always zero.
module pipe_fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] mem_wR,
   input  logic              mem_rf_we,
   input  logic [REG_AW-1:0] wb_wR,
   input  logic              wb_rf_we,
   output logic [1:0]        fwd_sel
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_rf_we && (mem_wR != '0) && (mem_wR == ex_rs);
   assign wb_hit  = wb_rf_we  && (wb_wR  != '0) && (wb_wR  == ex_rs);

   // Pick the youngest in-flight producer of ex_rs.
   always_comb begin
      fwd_sel = FWD_RF;
      if (mem_hit)
         fwd_sel = FWD_MEM;
      else if (wb_hit)
         fwd_sel = FWD_WB;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sequences PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB with stall/flush strobes, resolves load-use and taken-branch
// hazards, freezes the pipe during data-memory waits (with a timeout
// abort that raises a sticky bus_err) and produces EX forwarding selects.
//
// Build option: define PIPE_PERF_CNT_EN to enable the stall/flush
// performance counters; otherwise stall_cnt/flush_cnt read as zero.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int          TO_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_re1,
   input  logic              id_re2,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_wR,
   input  logic              ex_rf_we,
   input  logic              ex_is_load,
   input  logic              ex_br_taken,
   input  logic [REG_AW-1:0] mem_wR,
   input  logic              mem_rf_we,
   input  logic              mem_req,
   input  logic              mem_ack,
   input  logic [REG_AW-1:0] wb_wR,
   input  logic              wb_rf_we,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              idex_stall,
   output logic              exmem_stall,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic              memwb_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              bus_err,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   state_t           state;
   state_t           nxt_state;
   logic [TO_W-1:0]  to_cnt;
   logic [TO_W-1:0]  nxt_cnt;
   logic             set_err;
   logic             load_use;
   stall_t           stl;
   flush_t           fl;
   logic [1:0]       fwd_a_raw;
   logic [1:0]       fwd_b_raw;

   // Forwarding for both EX operands.
   pipe_fwd_unit u_fwd_a (
      .ex_rs     (ex_rs1),
      .mem_wR    (mem_wR),
      .mem_rf_we (mem_rf_we),
      .wb_wR     (wb_wR),
      .wb_rf_we  (wb_rf_we),
      .fwd_sel   (fwd_a_raw)
   );

   pipe_fwd_unit u_fwd_b (
      .ex_rs     (ex_rs2),
      .mem_wR    (mem_wR),
      .mem_rf_we (mem_rf_we),
      .wb_wR     (wb_wR),
      .wb_rf_we  (wb_rf_we),
      .fwd_sel   (fwd_b_raw)
   );

   // A load in EX whose result the ID instruction actually consumes.
   assign load_use = ex_is_load && ex_rf_we && (ex_wR != '0) &&
                     ((id_re1 && (id_rs1 == ex_wR)) ||
                      (id_re2 && (id_rs2 == ex_wR)));

   // Hazard priority and FSM next-state; memory freeze beats branch beats load-use.
   always_comb begin
      stl       = '0;
      fl        = '0;
      nxt_state = state;
      nxt_cnt   = to_cnt;
      set_err   = 1'b0;
      case (state)
         ST_RUN: begin
            if (mem_req && !mem_ack) begin
               // Freeze everything up to EX/MEM; EX is re-evaluated once the access completes.
               stl       = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1};
               fl.memwb  = 1'b1;
               nxt_state = ST_MEM_WAIT;
               nxt_cnt   = TO_W'(1);
            end else if (ex_br_taken) begin
               fl.ifid = 1'b1;
               fl.idex = 1'b1;
            end else if (load_use) begin
               // One bubble: hold IF/ID and PC, inject a NOP into ID/EX.
               stl.pc   = 1'b1;
               stl.ifid = 1'b1;
               fl.idex  = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            // Front of the pipe stays frozen; branches cannot flush it here.
            stl.pc   = 1'b1;
            stl.ifid = 1'b1;
            stl.idex = 1'b1;
            if (mem_ack) begin
               // Let MEM/WB capture the completed access.
               nxt_state = ST_RUN;
               nxt_cnt   = '0;
            end else begin
               stl.exmem = 1'b1;
               fl.memwb  = 1'b1;
               if (to_cnt == TO_W'(MEM_TIMEOUT)) begin
                  // Abort: drop the access by bubbling EX/MEM.
                  fl.exmem  = 1'b1;
                  set_err   = 1'b1;
                  nxt_state = ST_RUN;
                  nxt_cnt   = '0;
               end else begin
                  nxt_cnt = to_cnt + TO_W'(1);
               end
            end
         end
         default: begin
            nxt_state = ST_RUN;
            nxt_cnt   = '0;
         end
      endcase
   end

   // Strobes are quiet during reset; a flush overrides a hold on the same register.
   assign pc_stall    = !rst && stl.pc;
   assign ifid_stall  = !rst && stl.ifid  && !fl.ifid;
   assign idex_stall  = !rst && stl.idex  && !fl.idex;
   assign exmem_stall = !rst && stl.exmem && !fl.exmem;
   assign ifid_flush  = !rst && fl.ifid;
   assign idex_flush  = !rst && fl.idex;
   assign exmem_flush = !rst && fl.exmem;
   assign memwb_flush = !rst && fl.memwb;
   assign fwd_a       = rst ? FWD_RF : fwd_a_raw;
   assign fwd_b       = rst ? FWD_RF : fwd_b_raw;

   // FSM state, wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_RUN;
         to_cnt  <= '0;
         bus_err <= 1'b0;
      end else begin
         state  <= nxt_state;
         to_cnt <= nxt_cnt;
         if (set_err)
            bus_err <= 1'b1;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   // Free-running stall/flush event counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_stall)
            stall_cnt <= stall_cnt + 32'd1;
         if (ifid_flush || idex_flush)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand-written
// memory-wait/timeout/reset sequences and a randomized run against a
// cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int TMO = 4;
`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_wR, mem_wR, wb_wR;
   logic id_re1, id_re2, ex_rf_we, ex_is_load, ex_br_taken;
   logic mem_rf_we, mem_req, mem_ack, wb_rf_we;
   logic pc_stall, ifid_stall, idex_stall, exmem_stall;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic [1:0] fwd_a, fwd_b;
   logic bus_err;
   logic [31:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we),
      .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
      .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .mem_req(mem_req), .mem_ack(mem_ack),
      .wb_wR(wb_wR), .wb_rf_we(wb_rf_we),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
      .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .bus_err(bus_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct packed {
      logic rst;
      logic [4:0] id_rs1, id_rs2;
      logic id_re1, id_re2;
      logic [4:0] ex_rs1, ex_rs2, ex_wR;
      logic ex_rf_we, ex_is_load, ex_br_taken;
      logic [4:0] mem_wR;
      logic mem_rf_we, mem_req, mem_ack;
      logic [4:0] wb_wR;
      logic wb_rf_we;
   } in_t;

   // stl = {pc,ifid,idex,exmem} holds, fl = {ifid,idex,exmem,memwb} bubbles
   typedef struct packed {
      logic [3:0] stl;
      logic [3:0] fl;
      logic [1:0] fa, fb;
   } out_t;

   typedef struct {
      string name;
      in_t   i;
      out_t  o;
   } vec_t;

   int checks = 0;
   int failures = 0;

   // Model state: age of the pending access (0 = none), sticky error, perf counts
   int          m_age = 0;
   bit          m_berr = 1'b0;
   int unsigned m_sc = 0;
   int unsigned m_fc = 0;

   function automatic out_t eo(logic [3:0] s, logic [3:0] f, logic [1:0] a, logic [1:0] b);
      out_t o;
      o.stl = s; o.fl = f; o.fa = a; o.fb = b;
      return o;
   endfunction

   function automatic vec_t mk(string n, in_t i, out_t o);
      vec_t v;
      v.name = n; v.i = i; v.o = o;
      return v;
   endfunction

   // Producer priority for one EX source: youngest writer wins, x0 never forwarded
   function automatic logic [1:0] fsel(logic [4:0] rs, in_t v);
      if (rs == 5'd0) return 2'd0;
      if (v.mem_rf_we && v.mem_wR == rs) return 2'd1;
      if (v.wb_rf_we && v.wb_wR == rs) return 2'd2;
      return 2'd0;
   endfunction

   function automatic out_t mdl_comb(in_t v);
      out_t o = '0;
      bit lu;
      if (v.rst) return o;
      o.fa = fsel(v.ex_rs1, v);
      o.fb = fsel(v.ex_rs2, v);
      lu = v.ex_is_load && v.ex_rf_we && v.ex_wR != 0 &&
           ((v.id_re1 && v.id_rs1 == v.ex_wR) || (v.id_re2 && v.id_rs2 == v.ex_wR));
      if (m_age > 0) begin
         o.stl = 4'b1110;
         if (!v.mem_ack) begin
            o.fl[0] = 1'b1;
            if (m_age == TMO) o.fl[1] = 1'b1;   // abort: EX/MEM bubbled, not held
            else              o.stl[0] = 1'b1;
         end
      end else if (v.mem_req && !v.mem_ack) begin
         o.stl = 4'b1111; o.fl = 4'b0001;
      end else if (v.ex_br_taken) begin
         o.fl = 4'b1100;
      end else if (lu) begin
         o.stl = 4'b1100; o.fl = 4'b0100;
      end
      return o;
   endfunction

   task automatic mdl_update(in_t v);
      out_t o = mdl_comb(v);
      if (v.rst) begin
         m_age = 0; m_berr = 1'b0; m_sc = 0; m_fc = 0;
      end else begin
         if (o.stl[3]) m_sc = m_sc + 1;
         if (o.fl[3] || o.fl[2]) m_fc = m_fc + 1;
         if (m_age > 0) begin
            if (v.mem_ack) m_age = 0;
            else if (m_age == TMO) begin m_berr = 1'b1; m_age = 0; end
            else m_age = m_age + 1;
         end else if (v.mem_req && !v.mem_ack) begin
            m_age = 1;
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(in_t v);
      rst = v.rst; id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_re1 = v.id_re1; id_re2 = v.id_re2;
      ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_wR = v.ex_wR; ex_rf_we = v.ex_rf_we;
      ex_is_load = v.ex_is_load; ex_br_taken = v.ex_br_taken;
      mem_wR = v.mem_wR; mem_rf_we = v.mem_rf_we; mem_req = v.mem_req; mem_ack = v.mem_ack;
      wb_wR = v.wb_wR; wb_rf_we = v.wb_rf_we;
   endtask

   function automatic out_t sample();
      return eo({pc_stall, ifid_stall, idex_stall, exmem_stall},
                {ifid_flush, idex_flush, exmem_flush, memwb_flush}, fwd_a, fwd_b);
   endfunction

   // Called at a negedge: drive, settle, compare, then advance one clock.
   task automatic apply(string name, in_t v, out_t e, logic eb);
      drive(v);
      #1;
      chk(name, 32'(sample()), 32'(e));
      chk({name, "_berr"}, 32'(bus_err), 32'(eb));
      chk({name, "_scnt"}, stall_cnt, PERF ? m_sc : 32'd0);
      chk({name, "_fcnt"}, flush_cnt, PERF ? m_fc : 32'd0);
      mdl_update(v);
      @(negedge clk);
   endtask

   vec_t tbl[$];
   localparam out_t ZERO = '0;

   initial begin
      in_t b, i, r;
      out_t full, ackc, e;
      b = '0;
      r = '0; r.rst = 1'b1;
      full = eo(4'b1111, 4'b0001, 2'd0, 2'd0);
      ackc = eo(4'b1110, 4'b0000, 2'd0, 2'd0);

      // ---- directed table (RUN state, no pending access) ----
      tbl.push_back(mk("idle", b, ZERO));
      i = b; i.ex_is_load = 1; i.ex_rf_we = 1; i.ex_wR = 5; i.id_re1 = 1; i.id_rs1 = 5;
      tbl.push_back(mk("lu_rs1", i, eo(4'b1100, 4'b0100, 0, 0)));
      i = b; i.mem_wR = 5; i.mem_rf_we = 1; i.ex_rs1 = 5; i.id_re1 = 1; i.id_rs1 = 5;
      tbl.push_back(mk("lu_next", i, eo(0, 0, 2'd1, 0)));
      i = b; i.ex_is_load = 1; i.ex_rf_we = 1; i.ex_wR = 9; i.id_re1 = 1; i.id_rs1 = 3; i.id_re2 = 1; i.id_rs2 = 9;
      tbl.push_back(mk("lu_rs2", i, eo(4'b1100, 4'b0100, 0, 0)));
      i = b; i.ex_is_load = 1; i.ex_rf_we = 1; i.ex_wR = 5; i.id_rs1 = 5;
      tbl.push_back(mk("lu_noread", i, ZERO));
      i = b; i.ex_is_load = 1; i.ex_rf_we = 1; i.id_re1 = 1;
      tbl.push_back(mk("lu_x0", i, ZERO));
      i = b; i.ex_is_load = 1; i.ex_wR = 5; i.id_re1 = 1; i.id_rs1 = 5;
      tbl.push_back(mk("lu_nowe", i, ZERO));
      i = b; i.ex_rf_we = 1; i.ex_wR = 5; i.id_re1 = 1; i.id_rs1 = 5;
      tbl.push_back(mk("alu_dep", i, ZERO));
      i = b; i.mem_wR = 7; i.wb_wR = 7; i.ex_rs1 = 7; i.mem_rf_we = 1; i.wb_rf_we = 1;
      tbl.push_back(mk("fwd_prio", i, eo(0, 0, 2'd1, 0)));
      i.mem_rf_we = 0;
      tbl.push_back(mk("fwd_wb", i, eo(0, 0, 2'd2, 0)));
      i = b; i.mem_rf_we = 1; i.wb_rf_we = 1;
      tbl.push_back(mk("fwd_x0", i, ZERO));
      i = b; i.ex_rs1 = 4; i.mem_wR = 4; i.mem_rf_we = 1; i.ex_rs2 = 3; i.wb_wR = 3; i.wb_rf_we = 1;
      tbl.push_back(mk("fwd_ab", i, eo(0, 0, 2'd1, 2'd2)));
      i = b; i.ex_rs1 = 6; i.ex_rs2 = 6; i.mem_wR = 6; i.wb_wR = 6; i.mem_rf_we = 1; i.wb_rf_we = 1;
      tbl.push_back(mk("fwd_b_prio", i, eo(0, 0, 2'd1, 2'd1)));
      i = b; i.ex_is_load = 1; i.ex_rf_we = 1; i.ex_wR = 5; i.id_re1 = 1; i.id_rs1 = 5; i.ex_br_taken = 1;
      tbl.push_back(mk("br_vs_lu", i, eo(0, 4'b1100, 0, 0)));
      i = b; i.ex_br_taken = 1;
      tbl.push_back(mk("br_only", i, eo(0, 4'b1100, 0, 0)));
      i = b; i.mem_req = 1; i.mem_ack = 1; i.ex_is_load = 1; i.ex_rf_we = 1; i.ex_wR = 2; i.id_re2 = 1; i.id_rs2 = 2;
      tbl.push_back(mk("req_ack_lu", i, eo(4'b1100, 4'b0100, 0, 0)));

      // ---- reset state ----
      drive(r);
      @(negedge clk);
      i = tbl[14].i; i.rst = 1; i.mem_wR = 5; i.mem_rf_we = 1; i.ex_rs1 = 5; i.mem_req = 1;
      apply("reset_gate", i, ZERO, 1'b0);
      apply("reset_hold", r, ZERO, 1'b0);

      for (int k = 0; k < tbl.size(); k++)
         apply(tbl[k].name, tbl[k].i, tbl[k].o, 1'b0);

      // ---- memory wait: ack on the 4th request cycle ----
      i = b; i.mem_req = 1;
      apply("mw_enter", i, full, 1'b0);
      i.ex_br_taken = 1;
      apply("mw_br_ignored", i, full, 1'b0);
      i.ex_br_taken = 0;
      apply("mw_wait", i, full, 1'b0);
      i.mem_ack = 1;
      apply("mw_ack", i, ackc, 1'b0);
      apply("mw_done", b, ZERO, 1'b0);

      // ---- timeout: no ack, abort on 5th stalled cycle ----
      i = b; i.mem_req = 1;
      apply("to_enter", i, full, 1'b0);
      for (int k = 0; k < 3; k++) apply("to_wait", i, full, 1'b0);
      apply("to_abort", i, eo(4'b1110, 4'b0011, 0, 0), 1'b0);
      apply("to_after", b, ZERO, 1'b1);
      i = b; i.ex_br_taken = 1;
      apply("to_sticky", i, eo(0, 4'b1100, 0, 0), 1'b1);
      apply("to_rst", r, ZERO, 1'b1);

      // ---- ack coincides with the timeout cycle ----
      i = b; i.mem_req = 1;
      apply("at_enter", i, full, 1'b0);
      for (int k = 0; k < 3; k++) apply("at_wait", i, full, 1'b0);
      i.mem_ack = 1;
      apply("at_ack", i, ackc, 1'b0);
      apply("at_after", b, ZERO, 1'b0);

      // ---- reset in the middle of a wait ----
      i = b; i.mem_req = 1;
      apply("rm_enter", i, full, 1'b0);
      apply("rm_wait", i, full, 1'b0);
      i.rst = 1; i.ex_rs2 = 4; i.wb_wR = 4; i.wb_rf_we = 1;
      apply("rm_rst", i, ZERO, 1'b0);
      apply("rm_run", b, ZERO, 1'b0);

      // ---- perf counters: 3 stall cycles then 2 branch flushes ----
      apply("pf_rst", r, ZERO, 1'b0);
      i = b; i.mem_req = 1;
      apply("pf_s1", i, full, 1'b0);
      apply("pf_s2", i, full, 1'b0);
      i.mem_ack = 1;
      apply("pf_s3", i, ackc, 1'b0);
      i = b; i.ex_br_taken = 1;
      apply("pf_b1", i, eo(0, 4'b1100, 0, 0), 1'b0);
      apply("pf_b2", i, eo(0, 4'b1100, 0, 0), 1'b0);
      #1;
      chk("pf_stall_total", stall_cnt, PERF ? 32'd3 : 32'd0);
      chk("pf_flush_total", flush_cnt, PERF ? 32'd2 : 32'd0);

      // ---- randomized run against the model ----
      for (int n = 0; n < 2000; n++) begin
         i.rst = ($urandom_range(0, 63) == 0);
         i.id_rs1 = 5'($urandom_range(0, 3)); i.id_rs2 = 5'($urandom_range(0, 3));
         i.id_re1 = 1'($urandom); i.id_re2 = 1'($urandom);
         i.ex_rs1 = 5'($urandom_range(0, 3)); i.ex_rs2 = 5'($urandom_range(0, 3));
         i.ex_wR = 5'($urandom_range(0, 3)); i.ex_rf_we = 1'($urandom);
         i.ex_is_load = 1'($urandom); i.ex_br_taken = ($urandom_range(0, 3) == 0);
         i.mem_wR = 5'($urandom_range(0, 3)); i.mem_rf_we = 1'($urandom);
         i.mem_req = ($urandom_range(0, 2) == 0); i.mem_ack = ($urandom_range(0, 3) == 0);
         i.wb_wR = 5'($urandom_range(0, 3)); i.wb_rf_we = 1'($urandom);
         e = mdl_comb(i);
         apply("rand", i, e, m_berr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards, resolves taken branches/jumps, and freezes the pipe while a data-memory access waits for acknowledge.
- Drives per-stage stall/flush strobes and EX-stage operand-forwarding selects.
- Contains a small FSM and a memory-wait timeout counter.

Parameters:
MEM_TIMEOUT, 255, max cycles spent in MEM_WAIT before abort (1..65535)
TO_W, 16, width of timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset, sampled on posedge clk
id_rs1, id_rs2  in  5  source regs of instruction in ID
id_re1, id_re2  in  1  ID instruction actually reads rs1/rs2
ex_rs1, ex_rs2  in  5  source regs of instruction in EX
ex_wR  in  5  EX destination reg
ex_rf_we  in  1  EX writes regfile
ex_is_load  in  1  EX instruction is a load
ex_br_taken  in  1  branch/jump in EX resolved taken
mem_wR  in  5  MEM destination reg
mem_rf_we  in  1  MEM writes regfile
mem_req  in  1  MEM stage performs a data access this cycle
mem_ack  in  1  data bus acknowledge
wb_wR  in  5  WB destination reg
wb_rf_we  in  1  WB writes regfile
pc_stall, ifid_stall, idex_stall, exmem_stall  out  1  hold register contents
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  load bubble (all-zero control) next edge
fwd_a, fwd_b  out  2  EX operand select: 0 regfile, 1 EX/MEM ALU result, 2 WB write data
bus_err  out  1  sticky memory-timeout flag
stall_cnt, flush_cnt  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset state:
  - state=RUN, timeout counter=0, bus_err=0, counters=0.
  - While rst is high, all stall/flush outputs are 0 and fwd_a/fwd_b are 0.
- Outputs are combinational from state plus inputs; state, counter, bus_err and perf counters are registered.
- FSM states: RUN, MEM_WAIT.
- RUN, priority high→low:
  1. mem_req && !mem_ack:
     - Next state MEM_WAIT, counter←1.
     - This cycle: pc/ifid/idex/exmem_stall=1, memwb_flush=1.
     - Branch and load-use are ignored this cycle; the EX instruction is held and re-evaluated later.
  2. ex_br_taken:
     - ifid_flush=1, idex_flush=1; no stall.
  3. Load-use: ex_is_load && ex_rf_we && ex_wR!=0 && ((id_re1 && id_rs1==ex_wR) || (id_re2 && id_rs2==ex_wR)).
     - pc_stall=1, ifid_stall=1, idex_flush=1.
     - Exactly one bubble cycle.
  4. Otherwise: all strobes 0.
- MEM_WAIT:
  - Every cycle: pc/ifid/idex/exmem_stall=1, memwb_flush=1.
  - mem_ack=1:
    - Next state RUN, counter←0.
    - On this acknowledging cycle exmem_stall=0 and memwb_flush=0, so the MEM/WB register captures the completed access.
  - Else if counter==MEM_TIMEOUT:
    - bus_err←1, exmem_flush=1 (access dropped), next state RUN.
  - Else counter←counter+1.
  - mem_ack and timeout in the same cycle: ack wins, and bus_err is not set.
- Stall/flush conflict on one register: flush wins, except a register under stall from MEM_WAIT is never flushed by a branch.
- Forwarding (fwd_a shown; fwd_b is identical using ex_rs2):
  - 1 if mem_rf_we && mem_wR!=0 && mem_wR==ex_rs1.
  - Else 2 if wb_rf_we && wb_wR!=0 && wb_wR==ex_rs1.
  - Else 0.
  - EX/MEM has priority over WB.
  - x0 is never forwarded.
- bus_err: cleared only by rst.
- Reset mid-MEM_WAIT: next edge is RUN with counter cleared.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_cnt increments on every cycle with pc_stall=1.
  - flush_cnt increments on every cycle with ifid_flush||idex_flush.
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared by rst.
- Undefined: both ports are driven constant 0 and no counter flops exist. The port list is unchanged.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding (ST_RUN=1'b0, ST_MEM_WAIT=1'b1);
  - forwarding selects (FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2);
  - register-index width REG_AW=5.
- One sub-module: pipe_fwd_unit, purely combinational, two instances for operands A and B, producing a 2-bit select from rs/mem/wb fields.
- The FSM, hazard logic and counters stay in the top module.

Test Plan:
- Load-use: ex_is_load=1, ex_wR=5, ex_rf_we=1, id_re1=1, id_rs1=5 → exactly one cycle of pc_stall=ifid_stall=idex_flush=1; the next cycle, with the load in MEM, all strobes are 0.
- Forwarding priority: mem_wR=wb_wR=ex_rs1=7, both we=1 → fwd_a=1. With mem_rf_we=0 → fwd_a=2. With ex_rs1=0 and both wR=0 → fwd_a=0.
- Branch vs load-use in the same cycle: ex_br_taken=1 plus load-use condition → ifid_flush=idex_flush=1, pc_stall=0.
- Memory wait: mem_req=1, ack after 3 cycles → 3 cycles of full stall with memwb_flush=1. On the ack cycle exmem_stall=0 and memwb_flush=0. State returns to RUN and bus_err stays 0.
- Timeout: MEM_TIMEOUT=4, mem_req=1, no ack → exmem_flush=1 on the 5th stalled cycle, bus_err=1 from the next cycle onward until rst. Ack arriving on the timeout cycle → no bus_err.
- Reset in MEM_WAIT, and PIPE_PERF_CNT_EN build: assert rst for 1 cycle mid-wait → all strobes 0 during rst, state RUN and counters 0 after. Perf build: 3 stalls plus 2 branch flushes → stall_cnt=3, flush_cnt=2.
